// File: rtl/arrow_pkg.sv
// -----------------------------------------------------------------------------
// arrow_pkg
// Constants and types shared by the arrow scroll scheduler and the pixel
// renderer: lane numbering, y coordinate width, target row and hit window.
// -----------------------------------------------------------------------------
package arrow_pkg;

  typedef logic [1:0] lane_t;

  localparam lane_t LANE_LEFT  = 2'd0;
  localparam lane_t LANE_DOWN  = 2'd1;
  localparam lane_t LANE_UP    = 2'd2;
  localparam lane_t LANE_RIGHT = 2'd3;

  localparam int YW          = 10;  // y coordinate width
  localparam int TARGET_Y    = 36;  // row of the fixed target frames (vposframe)
  localparam int HIT_WIN     = 16;  // max |y - TARGET_Y| that still counts as a hit
  localparam int PERFECT_WIN = HIT_WIN / 4;

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } state_t;

endpackage

// File: rtl/arrow_scroll_scheduler_free_slot_finder.sv
// -----------------------------------------------------------------------------
// free_slot_finder
// Priority encoder returning the lowest-index slot whose valid bit is clear.
//   valid    : per-slot live flags
//   any_free : at least one slot is free
//   free_idx : lowest free slot index (0 when none is free)
// -----------------------------------------------------------------------------
module free_slot_finder #(
  parameter int SLOTS = 8
) (
  input  logic [SLOTS-1:0]         valid,
  output logic                     any_free,
  output logic [$clog2(SLOTS)-1:0] free_idx
);

  localparam int IW = $clog2(SLOTS);

  assign any_free = ~&valid;

  // NOTE: assigning a default before the loop keeps this purely combinational;
  // a path that leaves free_idx unassigned would infer a latch.
  always_comb begin
    free_idx = '0;
    // Walk downward so the last hit, i.e. the lowest free index, wins.
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!valid[i]) free_idx = IW'(i);
    end
  end

endmodule

// File: rtl/arrow_scroll_scheduler.sv
// -----------------------------------------------------------------------------
// arrow_scroll_scheduler
// Owns the pool of scrolling arrow sprites. On each frame_tick it scans every
// slot once (one slot per cycle) to resolve presses as hits, retire arrows past
// the window as misses, and move the rest up by SPEED pixels. Spawns are taken
// only while idle, so the renderer sees stable positions outside the scan.
//   clk, rst                 : clock, asynchronous active-high reset
//   frame_tick               : start-of-vblank pulse, launches a scan
//   spawn_valid/lane/ready   : spawn handshake from the step-chart sequencer
//   press[3:0]               : per-lane debounced button pulses
//   rd_idx -> rd_valid/lane/y: renderer slot read port (combinational)
//   hit_valid/lane/perfect   : one-cycle hit report
//   miss_valid/lane          : one-cycle miss report
//   busy                     : scan in progress
// -----------------------------------------------------------------------------
module arrow_scroll_scheduler #(
  parameter int SLOTS    = 8,
  parameter int YW       = arrow_pkg::YW,
  parameter int SPEED    = 2,
  parameter int SPAWN_Y  = 480,
  parameter int TARGET_Y = arrow_pkg::TARGET_Y,
  parameter int HIT_WIN  = arrow_pkg::HIT_WIN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_tick,
  input  logic                     spawn_valid,
  input  logic [1:0]               spawn_lane,
  output logic                     spawn_ready,
  input  logic [3:0]               press,
  input  logic [$clog2(SLOTS)-1:0] rd_idx,
  output logic                     rd_valid,
  output logic [1:0]               rd_lane,
  output logic [YW-1:0]            rd_y,
  output logic                     hit_valid,
  output logic [1:0]               hit_lane,
  output logic                     hit_perfect,
  output logic                     miss_valid,
  output logic [1:0]               miss_lane,
  output logic                     busy
);

  import arrow_pkg::*;

  localparam int IW = $clog2(SLOTS);

  localparam logic [YW-1:0] TGT    = YW'(TARGET_Y);
  localparam logic [YW-1:0] WIN    = YW'(HIT_WIN);
  localparam logic [YW-1:0] PERF   = YW'(HIT_WIN / 4);
  localparam logic [YW-1:0] STEP   = YW'(SPEED);
  localparam logic [YW-1:0] START  = YW'(SPAWN_Y);
  // Below this row one more move would carry the arrow past the window.
  localparam logic [YW-1:0] MISS_Y = YW'(TARGET_Y - HIT_WIN + SPEED);
  localparam logic [IW-1:0] LAST   = IW'(SLOTS - 1);

  state_t          state;
  logic [IW-1:0]   idx;
  logic [3:0]      snap;
  logic [3:0]      pend;
  logic [SLOTS-1:0] slot_valid;
  lane_t           slot_lane [SLOTS];
  logic [YW-1:0]   slot_y    [SLOTS];

  logic            any_free;
  logic [IW-1:0]   free_idx;
  logic            spawn_fire;

  free_slot_finder #(.SLOTS(SLOTS)) u_free (
    .valid    (slot_valid),
    .any_free (any_free),
    .free_idx (free_idx)
  );

  assign spawn_ready = (state == ST_IDLE) & ~frame_tick & any_free;
  assign spawn_fire  = spawn_valid & spawn_ready;

  // Slot under the scan pointer.
  logic          cur_valid;
  lane_t         cur_lane;
  logic [YW-1:0] cur_y;
  logic [YW-1:0] cur_dist;
  logic          hit_now;
  logic          miss_now;
  logic          move_now;

  assign cur_valid = slot_valid[idx];
  assign cur_lane  = slot_lane[idx];
  assign cur_y     = slot_y[idx];
  assign cur_dist  = (cur_y >= TGT) ? (cur_y - TGT) : (TGT - cur_y);
  assign hit_now   = (state == ST_SCAN) & cur_valid & snap[cur_lane] & (cur_dist <= WIN);
  assign miss_now  = (state == ST_SCAN) & cur_valid & ~hit_now & (cur_y < MISS_Y);
  assign move_now  = (state == ST_SCAN) & cur_valid & ~hit_now & ~miss_now;

  assign rd_valid = slot_valid[rd_idx];
  assign rd_lane  = slot_lane[rd_idx];
  assign rd_y     = slot_y[rd_idx];

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      snap        <= '0;
      pend        <= '0;
      slot_valid  <= '0;
      busy        <= 1'b0;
      hit_valid   <= 1'b0;
      hit_lane    <= '0;
      hit_perfect <= 1'b0;
      miss_valid  <= 1'b0;
      miss_lane   <= '0;
    end else begin
      hit_valid  <= 1'b0;
      miss_valid <= 1'b0;

      // Presses outside the snapshot cycle wait for the next frame.
      if (state == ST_IDLE && frame_tick) pend <= '0;
      else                                pend <= pend | press;

      case (state)
        ST_IDLE: begin
          if (frame_tick) begin
            state <= ST_SCAN;
            idx   <= '0;
            snap  <= pend | press;
            busy  <= 1'b1;
          end else if (spawn_fire) begin
            slot_valid[free_idx] <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (hit_now) begin
            slot_valid[idx]  <= 1'b0;
            hit_valid        <= 1'b1;
            hit_lane         <= cur_lane;
            hit_perfect      <= (cur_dist <= PERF);
            snap[cur_lane]   <= 1'b0;  // one press hits at most one arrow
          end else if (miss_now) begin
            slot_valid[idx]  <= 1'b0;
            miss_valid       <= 1'b1;
            miss_lane        <= cur_lane;
          end
          if (idx == LAST) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: lane and y form a register file qualified by slot_valid, so they
  // carry no reset; only the valid bits must clear.
  always_ff @(posedge clk) begin
    if (spawn_fire) begin
      slot_lane[free_idx] <= spawn_lane;
      slot_y[free_idx]    <= START;
    end else if (move_now) begin
      slot_y[idx] <= cur_y - STEP;
    end
  end

endmodule

// File: tb/tb_arrow_scroll_scheduler.sv
// -----------------------------------------------------------------------------
// tb_arrow_scroll_scheduler
// Directed bench for arrow_scroll_scheduler with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_arrow_scroll_scheduler;

  localparam int SLOTS = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       spawn_valid;
  logic [1:0] spawn_lane;
  logic       spawn_ready;
  logic [3:0] press;
  logic [2:0] rd_idx;
  logic       rd_valid;
  logic [1:0] rd_lane;
  logic [9:0] rd_y;
  logic       hit_valid;
  logic [1:0] hit_lane;
  logic       hit_perfect;
  logic       miss_valid;
  logic [1:0] miss_lane;
  logic       busy;

  arrow_scroll_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .spawn_valid (spawn_valid),
    .spawn_lane  (spawn_lane),
    .spawn_ready (spawn_ready),
    .press       (press),
    .rd_idx      (rd_idx),
    .rd_valid    (rd_valid),
    .rd_lane     (rd_lane),
    .rd_y        (rd_y),
    .hit_valid   (hit_valid),
    .hit_lane    (hit_lane),
    .hit_perfect (hit_perfect),
    .miss_valid  (miss_valid),
    .miss_lane   (miss_lane),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Per-frame observations.
  int         f_hits;
  int         f_misses;
  int         f_busy;
  int         f_both;
  logic [1:0] f_hl;
  logic       f_hp;
  logic [1:0] f_ml;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_slot(input string tag, input int i, input logic ev,
                            input logic [1:0] el, input logic [9:0] ey);
    rd_idx = 3'(i);
    #1;
    check({tag, "_valid"}, 32'(rd_valid), 32'(ev));
    if (ev) begin
      check({tag, "_lane"}, 32'(rd_lane), 32'(el));
      check({tag, "_y"}, 32'(rd_y), 32'(ey));
    end
  endtask

  task automatic spawn(input logic [1:0] lane);
    int waited = 0;
    spawn_valid = 1'b1;
    spawn_lane  = lane;
    #1;
    while (!spawn_ready && waited < 100) begin
      @(negedge clk); #1;
      waited++;
    end
    check("spawn_accept", 32'(spawn_ready), 32'd1);
    @(negedge clk);
    spawn_valid = 1'b0;
  endtask

  // One frame: tick (with press p in the snapshot cycle), then observe the scan.
  // mp is pulsed for one cycle in the middle of the scan.
  task automatic frame(input logic [3:0] p, input logic [3:0] mp);
    f_hits = 0; f_misses = 0; f_busy = 0; f_both = 0;
    press = p;
    frame_tick = 1'b1;
    for (int c = 0; c < SLOTS + 3; c++) begin
      @(negedge clk);
      if (c == 0) frame_tick = 1'b0;
      if (busy) f_busy++;
      if (hit_valid)  begin f_hits++;   f_hl = hit_lane; f_hp = hit_perfect; end
      if (miss_valid) begin f_misses++; f_ml = miss_lane; end
      if (hit_valid && miss_valid) f_both++;
      press = (c == 2) ? mp : 4'b0;
    end
    press = 4'b0;
  endtask

  task automatic run_frames(input string tag, input int n);
    int pulses = 0;
    int both = 0;
    for (int i = 0; i < n; i++) begin
      frame(4'b0, 4'b0);
      pulses += f_hits + f_misses;
      both   += f_both;
    end
    check({tag, "_quiet"}, 32'(pulses), 32'd0);
    check({tag, "_exclusive"}, 32'(both), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int waited;
    logic [7:0] live;

    rst = 1'b1; frame_tick = 1'b0; spawn_valid = 1'b0; spawn_lane = '0;
    press = '0; rd_idx = '0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hit", 32'(hit_valid), 32'd0);
    check("rst_miss", 32'(miss_valid), 32'd0);
    check_slot("rst_s0", 0, 1'b0, 2'd0, 10'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(spawn_ready), 32'd1);

    // Scroll: one arrow in lane 2 moves 480 -> 478 and busy lasts 8 cycles.
    spawn(2'd2);
    check_slot("scroll_before", 0, 1'b1, 2'd2, 10'd480);
    frame(4'b0, 4'b0);
    check("scroll_busy_cycles", 32'(f_busy), 32'd8);
    check_slot("scroll_after", 0, 1'b1, 2'd2, 10'd478);

    // Perfect hit: scroll to y=36, press lane 2 while idle, then tick.
    run_frames("to_target", 221);
    check_slot("at_target", 0, 1'b1, 2'd2, 10'd36);
    press = 4'b0100;
    @(negedge clk);
    press = 4'b0;
    frame(4'b0, 4'b0);
    check("perfect_hits", 32'(f_hits), 32'd1);
    check("perfect_lane", 32'(f_hl), 32'd2);
    check("perfect_flag", 32'(f_hp), 32'd1);
    check("perfect_misses", 32'(f_misses), 32'd0);
    check_slot("perfect_freed", 0, 1'b0, 2'd0, 10'd0);

    // Miss boundary: slot0 lane 2 and slot1 lane 1 both reach y=22.
    spawn(2'd2);
    spawn(2'd1);
    run_frames("to_22", 229);
    check_slot("edge_s0", 0, 1'b1, 2'd2, 10'd22);
    frame(4'b0, 4'b0);
    check("edge22_pulses", 32'(f_hits + f_misses), 32'd0);
    check_slot("edge20_s0", 0, 1'b1, 2'd2, 10'd20);
    check_slot("edge20_s1", 1, 1'b1, 2'd1, 10'd20);
    // Lane 2 unpressed -> miss; lane 1 pressed at d=16 -> non-perfect hit.
    frame(4'b0010, 4'b0);
    check("edge_misses", 32'(f_misses), 32'd1);
    check("edge_miss_lane", 32'(f_ml), 32'd2);
    check("edge_hits", 32'(f_hits), 32'd1);
    check("edge_hit_lane", 32'(f_hl), 32'd1);
    check("edge_hit_perfect", 32'(f_hp), 32'd0);
    check("edge_exclusive", 32'(f_both), 32'd0);
    check_slot("edge_freed0", 0, 1'b0, 2'd0, 10'd0);
    check_slot("edge_freed1", 1, 1'b0, 2'd0, 10'd0);

    // Same-lane pair: slot0 leads slot1 by 4 pixels, both lane 0.
    spawn(2'd0);
    run_frames("pair_lead", 2);
    spawn(2'd0);
    run_frames("pair_run", 217);
    check_slot("pair_s0", 0, 1'b1, 2'd0, 10'd42);
    check_slot("pair_s1", 1, 1'b1, 2'd0, 10'd46);
    // Press during the scan goes to pend; it must not hit this frame.
    frame(4'b0, 4'b0001);
    check("pend_no_hit", 32'(f_hits), 32'd0);
    check_slot("pend_s0", 0, 1'b1, 2'd0, 10'd40);
    // Pending press applies now: only the lowest-index arrow is hit.
    frame(4'b0, 4'b0);
    check("pair_hits", 32'(f_hits), 32'd1);
    check("pair_hit_lane", 32'(f_hl), 32'd0);
    check("pair_hit_perfect", 32'(f_hp), 32'd1);
    check_slot("pair_s0_freed", 0, 1'b0, 2'd0, 10'd0);
    check_slot("pair_s1_moved", 1, 1'b1, 2'd0, 10'd42);
    // Press on an empty lane produces nothing.
    frame(4'b1000, 4'b0);
    check("lane3_pulses", 32'(f_hits + f_misses), 32'd0);
    check_slot("lane3_s1", 1, 1'b1, 2'd0, 10'd40);

    // Full pool: fill the 7 free slots, then hold a 9th request.
    for (int i = 0; i < 7; i++) spawn(2'd2);
    #1;
    check("full_ready", 32'(spawn_ready), 32'd0);
    spawn_valid = 1'b1;
    spawn_lane  = 2'd3;
    repeat (3) @(negedge clk);
    #1;
    check("full_held_ready", 32'(spawn_ready), 32'd0);
    check_slot("full_s1_kept", 1, 1'b1, 2'd0, 10'd40);
    frame(4'b0001, 4'b0);
    spawn_valid = 1'b0;
    check("full_hits", 32'(f_hits), 32'd1);
    check("full_hit_lane", 32'(f_hl), 32'd0);
    check_slot("full_s1_new", 1, 1'b1, 2'd3, 10'd480);
    check_slot("full_s0_moved", 0, 1'b1, 2'd2, 10'd478);
    #1;
    check("full_again", 32'(spawn_ready), 32'd0);

    // Asynchronous reset in the middle of a scan with a live pool.
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    press = 4'hf;
    rst = 1'b1;
    #1;
    live = '0;
    for (int i = 0; i < SLOTS; i++) begin
      rd_idx = 3'(i);
      #1;
      live[i] = rd_valid;
    end
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_hit", 32'(hit_valid), 32'd0);
    check("midrst_miss", 32'(miss_valid), 32'd0);
    check("midrst_hit_lane", 32'(hit_lane), 32'd0);
    check("midrst_live", 32'(live), 32'd0);
    @(negedge clk);
    press = 4'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_ready", 32'(spawn_ready), 32'd1);

    // Spawn coincident with frame_tick waits for the whole scan.
    @(negedge clk);
    spawn_valid = 1'b1;
    spawn_lane  = 2'd1;
    frame_tick  = 1'b1;
    #1;
    check("tick_blocks_spawn", 32'(spawn_ready), 32'd0);
    @(negedge clk);
    frame_tick = 1'b0;
    waited = 0;
    #1;
    while (!spawn_ready && waited < 50) begin
      @(negedge clk); #1;
      waited++;
    end
    check("tick_spawn_wait", 32'(waited), 32'd8);
    @(negedge clk);
    spawn_valid = 1'b0;
    check_slot("tick_spawn_s0", 0, 1'b1, 2'd1, 10'd480);
    check_slot("tick_spawn_s1", 1, 1'b0, 2'd0, 10'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
